aram_1r1w1ck_init_pipe: RTL and testbench

Parametrised single-clock simple dual-port RAM: one write port, one read port.
- Adds per-lane write enables and a self-clearing init sequence after reset.
- Adds same-address write-to-read bypass and a selectable 1- or 2-cycle read pipeline with a valid strobe.
- Used as the generic storage primitive for link-layer replay buffers and host-side data queues.

---
 rtl/aram_pkg.sv | 23 ++
 rtl/aram_1r1w1ck_core.sv | 32 +++
 rtl/aram_1r1w1ck_init_pipe.sv | 170 +++++++++++++++++
 tb/tb_aram_1r1w1ck_init_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/aram_pkg.sv
// Shared types and elaboration helpers for the aram_1r1w1ck family of RAM wrappers.
package aram_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   // Minimum of 1 so a single-entry RAM still gets a legal address port.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int nlane(input int width, input int lane_w);
      return width / lane_w;
   endfunction

endpackage

// File: rtl/aram_1r1w1ck_core.sv
// Bare DEPTH x WIDTH storage array: per-lane write enable, registered read, no reset.
module aram_1r1w1ck_core #(
   parameter int WIDTH  = 56,
   parameter int DEPTH  = 64,
   parameter int AWIDTH = 6,
   parameter int LANE_W = 8,
   parameter int NLANE  = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [NLANE-1:0]  wbe,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [AWIDTH-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: no reset on the array or its read register; a reset here would stop
   // block-RAM inference. The wrapper's init sweep provides the known contents.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NLANE; i++) begin
            if (wbe[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/aram_1r1w1ck_init_pipe.sv
// Simple dual-port RAM wrapper: post-reset init sweep, write-to-read bypass,
// range checking and a 1- or 2-cycle read pipeline with valid/error strobes.
module aram_1r1w1ck_init_pipe
   import aram_pkg::*;
#(
   parameter int               WIDTH    = 56,
   parameter int               DEPTH    = 64,
   parameter int               AWIDTH   = clog2(DEPTH),
   parameter int               LANE_W   = 8,
   parameter int               RD_LAT   = 1,
   parameter int               BYPASS   = 1,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           ena,
   input  logic                           wea,
   input  logic [nlane(WIDTH,LANE_W)-1:0] wbe,
   input  logic [AWIDTH-1:0]              addra,
   input  logic [WIDTH-1:0]               dia,
   input  logic                           enb,
   input  logic [AWIDTH-1:0]              addrb,
   output logic [WIDTH-1:0]               dob,
   output logic                           dob_valid,
   output logic                           addr_err,
   output logic                           init_done
);

   localparam int NLANE = nlane(WIDTH, LANE_W);

   if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
      $error("aram_1r1w1ck_init_pipe: RD_LAT must be 1 or 2");
   end
   if ((WIDTH % LANE_W) != 0) begin : g_bad_lane_w
      $error("aram_1r1w1ck_init_pipe: WIDTH must be a multiple of LANE_W");
   end

   state_t            state, state_nxt;
   logic [AWIDTH-1:0] init_ptr, init_ptr_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= INIT;
         init_ptr <= '0;
      end else begin
         state    <= state_nxt;
         init_ptr <= init_ptr_nxt;
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt    = state;
      init_ptr_nxt = init_ptr;
      case (state)
         INIT: begin
            init_ptr_nxt = init_ptr + 1'b1;
            if (init_ptr == AWIDTH'(DEPTH - 1)) begin
               state_nxt    = READY;
               init_ptr_nxt = '0;
            end
         end
         READY:   state_nxt = READY;
         default: state_nxt = INIT;
      endcase
   end

   assign init_done = (state == READY);

   // With a power-of-two depth every address is legal, so skip the compare.
   logic wr_in_range, rd_in_range;
   if (DEPTH == (1 << AWIDTH)) begin : g_full_range
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
   end else begin : g_part_range
      assign wr_in_range = (addra < AWIDTH'(DEPTH));
      assign rd_in_range = (addrb < AWIDTH'(DEPTH));
   end

   logic wr_acc, rd_acc, collide;
   assign wr_acc  = init_done & ena & wea & wr_in_range;
   assign rd_acc  = init_done & enb;
   assign collide = (BYPASS != 0) & wr_acc & rd_acc & (addra == addrb);

   logic [NLANE-1:0] core_wbe;
   logic [WIDTH-1:0] core_q;

   assign core_wbe = init_done ? wbe : {NLANE{1'b1}};

   aram_1r1w1ck_core #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AWIDTH(AWIDTH),
      .LANE_W(LANE_W),
      .NLANE (NLANE)
   ) u_core (
      .clk  (clk),
      .we   (init_done ? wr_acc : 1'b1),
      .wbe  (core_wbe),
      .waddr(init_done ? addra : init_ptr),
      .wdata(init_done ? dia : INIT_VAL),
      .re   (rd_acc & rd_in_range),
      .raddr(addrb),
      .rdata(core_q)
   );

   // Stage 1 sidebands. s1_zero comes up set so dob reads 0 straight out of reset.
   logic             s1_valid, s1_zero, s1_byp;
   logic [NLANE-1:0] s1_wbe;
   logic [WIDTH-1:0] s1_wd, s1_data;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_zero  <= 1'b1;
         s1_byp   <= 1'b0;
      end else begin
         s1_valid <= rd_acc;
         if (rd_acc) begin
            s1_zero <= ~rd_in_range;
            s1_byp  <= collide;
         end
      end
   end

   // Bypass payload is only consulted while s1_byp is set, so it needs no reset.
   always_ff @(posedge clk) begin
      if (rd_acc) begin
         s1_wbe <= wbe;
         s1_wd  <= dia;
      end
   end

   always_comb begin
      s1_data = core_q;
      if (s1_byp) begin
         for (int i = 0; i < NLANE; i++) begin
            if (s1_wbe[i]) s1_data[i*LANE_W +: LANE_W] = s1_wd[i*LANE_W +: LANE_W];
         end
      end
      if (s1_zero) s1_data = '0;
   end

   if (RD_LAT == 2) begin : g_lat2
      logic             s2_valid, s2_err;
      logic [WIDTH-1:0] s2_data;

      always_ff @(posedge clk) begin
         if (reset) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_data  <= '0;
         end else begin
            s2_valid <= s1_valid;
            s2_err   <= s1_valid & s1_zero;
            if (s1_valid) s2_data <= s1_data;
         end
      end

      assign dob       = s2_data;
      assign dob_valid = s2_valid;
      assign addr_err  = s2_err;
   end else begin : g_lat1
      assign dob       = s1_data;
      assign dob_valid = s1_valid;
      assign addr_err  = s1_valid & s1_zero;
   end

endmodule

// File: tb/tb_aram_1r1w1ck_init_pipe.sv
// Directed bench: default instance (DEPTH=64, RD_LAT=1, BYPASS=1) and a
// DEPTH=48, RD_LAT=2, BYPASS=0 instance, each run through its own sequence.
module tb_aram_1r1w1ck_init_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Default instance
   logic        reset1, ena1, wea1, enb1;
   logic [6:0]  wbe1;
   logic [5:0]  addra1, addrb1;
   logic [55:0] dia1, dob1;
   logic        dob_valid1, addr_err1, init_done1;

   aram_1r1w1ck_init_pipe dut1 (
      .clk(clk), .reset(reset1), .ena(ena1), .wea(wea1), .wbe(wbe1),
      .addra(addra1), .dia(dia1), .enb(enb1), .addrb(addrb1),
      .dob(dob1), .dob_valid(dob_valid1), .addr_err(addr_err1), .init_done(init_done1)
   );

   // Non-power-of-two depth, two-stage read, read-first collision
   logic        reset2, ena2, wea2, enb2;
   logic [6:0]  wbe2;
   logic [5:0]  addra2, addrb2;
   logic [55:0] dia2, dob2;
   logic        dob_valid2, addr_err2, init_done2;

   aram_1r1w1ck_init_pipe #(.DEPTH(48), .RD_LAT(2), .BYPASS(0)) dut2 (
      .clk(clk), .reset(reset2), .ena(ena2), .wea(wea2), .wbe(wbe2),
      .addra(addra2), .dia(dia2), .enb(enb2), .addrb(addrb2),
      .dob(dob2), .dob_valid(dob_valid2), .addr_err(addr_err2), .init_done(init_done2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [55:0] D_A   = 56'h11_2233_4455_6677;
   localparam logic [55:0] D_FF  = 56'hFF_FFFF_FFFF_FFFF;
   localparam logic [55:0] D_MRG = 56'h11_2233_4455_66FF;

   function automatic logic [55:0] pat(input int i);
      return 56'(64'h0000_1111_2222_3333 * (i + 1));
   endfunction

   initial begin
      reset1 = 1'b1; ena1 = 1'b0; wea1 = 1'b0; enb1 = 1'b0;
      wbe1 = '0; addra1 = '0; addrb1 = '0; dia1 = '0;
      reset2 = 1'b1; ena2 = 1'b0; wea2 = 1'b0; enb2 = 1'b0;
      wbe2 = '0; addra2 = '0; addrb2 = '0; dia2 = '0;

      // ---------------- default instance ----------------
      tick();
      tick();
      check("rst_init_done", 64'(init_done1), 64'd0);
      check("rst_dob",       64'(dob1),       64'd0);
      check("rst_valid",     64'(dob_valid1), 64'd0);
      check("rst_err",       64'(addr_err1),  64'd0);

      // Reads are ignored throughout the 64-cycle sweep
      reset1 = 1'b0; enb1 = 1'b1; addrb1 = 6'd5;
      for (int i = 1; i < 64; i++) begin
         tick();
         check("init_valid", 64'(dob_valid1), 64'd0);
         check("init_busy",  64'(init_done1), 64'd0);
      end
      tick();
      check("init_done_64", 64'(init_done1), 64'd1);
      check("init_valid_64", 64'(dob_valid1), 64'd0);
      tick();
      check("first_rd_valid", 64'(dob_valid1), 64'd1);
      check("first_rd_data",  64'(dob1),       64'd0);

      // Full write then read, latency 1
      enb1 = 1'b0; ena1 = 1'b1; wea1 = 1'b1; wbe1 = 7'h7F; addra1 = 6'd10; dia1 = D_A;
      tick();
      check("wr_no_valid", 64'(dob_valid1), 64'd0);
      ena1 = 1'b0; wea1 = 1'b0; enb1 = 1'b1; addrb1 = 6'd10;
      tick();
      check("rd10_valid", 64'(dob_valid1), 64'd1);
      check("rd10_data",  64'(dob1),       64'(D_A));
      enb1 = 1'b0;
      tick();
      check("hold_valid", 64'(dob_valid1), 64'd0);
      check("hold_data",  64'(dob1),       64'(D_A));

      // Collision, write-first merge
      ena1 = 1'b1; wea1 = 1'b1; wbe1 = 7'h01; addra1 = 6'd10; dia1 = D_FF;
      enb1 = 1'b1; addrb1 = 6'd10;
      tick();
      check("byp1_valid", 64'(dob_valid1), 64'd1);
      check("byp1_data",  64'(dob1),       64'(D_MRG));
      ena1 = 1'b0; wea1 = 1'b0;
      tick();
      check("byp1_after", 64'(dob1), 64'(D_MRG));
      enb1 = 1'b0;

      // Reset arriving with a read in the same cycle as the read request
      ena1 = 1'b1; wea1 = 1'b1; wbe1 = 7'h7F; addra1 = 6'd3; dia1 = 56'hAB;
      tick();
      ena1 = 1'b0; wea1 = 1'b0; enb1 = 1'b1; addrb1 = 6'd3; reset1 = 1'b1;
      tick();
      check("mid_rst_valid", 64'(dob_valid1), 64'd0);
      check("mid_rst_done",  64'(init_done1), 64'd0);
      check("mid_rst_dob",   64'(dob1),       64'd0);
      reset1 = 1'b0;
      for (int i = 1; i < 64; i++) begin
         tick();
         check("reinit_valid", 64'(dob_valid1), 64'd0);
      end
      tick();
      check("reinit_done", 64'(init_done1), 64'd1);
      tick();
      check("reinit_rd3_valid", 64'(dob_valid1), 64'd1);
      check("reinit_rd3_data",  64'(dob1),       64'd0);
      enb1 = 1'b0;

      // ---------------- DEPTH=48, RD_LAT=2, BYPASS=0 ----------------
      reset2 = 1'b0;
      for (int i = 1; i < 48; i++) begin
         tick();
         check("d48_init_busy", 64'(init_done2), 64'd0);
      end
      tick();
      check("d48_init_done", 64'(init_done2), 64'd1);

      ena2 = 1'b1; wea2 = 1'b1; wbe2 = 7'h7F; addra2 = 6'd10; dia2 = D_A;
      tick();
      // Collision, read-first
      wbe2 = 7'h01; dia2 = D_FF; enb2 = 1'b1; addrb2 = 6'd10;
      tick();
      check("byp0_lat_gap", 64'(dob_valid2), 64'd0);
      ena2 = 1'b0; wea2 = 1'b0; enb2 = 1'b0;
      tick();
      check("byp0_valid", 64'(dob_valid2), 64'd1);
      check("byp0_data",  64'(dob2),       64'(D_A));
      enb2 = 1'b1;
      tick();
      enb2 = 1'b0;
      tick();
      check("byp0_after", 64'(dob2), 64'(D_MRG));

      // Back-to-back reads at latency 2
      ena2 = 1'b1; wea2 = 1'b1; wbe2 = 7'h7F;
      for (int i = 0; i < 4; i++) begin
         addra2 = 6'(i); dia2 = pat(i);
         tick();
      end
      ena2 = 1'b0; wea2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         enb2 = 1'b1; addrb2 = 6'(i);
         tick();
         if (i == 0) begin
            check("pipe_first_gap", 64'(dob_valid2), 64'd0);
         end else begin
            check("pipe_valid", 64'(dob_valid2), 64'd1);
            check("pipe_data",  64'(dob2),       64'(pat(i - 1)));
         end
      end
      enb2 = 1'b0;
      tick();
      check("pipe_last_valid", 64'(dob_valid2), 64'd1);
      check("pipe_last_data",  64'(dob2),       64'(pat(3)));
      tick();
      check("pipe_end_valid", 64'(dob_valid2), 64'd0);
      check("pipe_end_hold",  64'(dob2),       64'(pat(3)));

      // Out-of-range write dropped, out-of-range read flagged
      ena2 = 1'b1; wea2 = 1'b1; addra2 = 6'd50; dia2 = 56'h5A5A;
      tick();
      ena2 = 1'b0; wea2 = 1'b0;
      enb2 = 1'b1; addrb2 = 6'd50;
      tick();
      addrb2 = 6'd1;
      tick();
      check("oor_valid", 64'(dob_valid2), 64'd1);
      check("oor_data",  64'(dob2),       64'd0);
      check("oor_err",   64'(addr_err2),  64'd1);
      addrb2 = 6'd47;
      tick();
      check("inr_data", 64'(dob2),      64'(pat(1)));
      check("inr_err",  64'(addr_err2), 64'd0);
      enb2 = 1'b0;
      tick();
      check("last_entry_valid", 64'(dob_valid2), 64'd1);
      check("last_entry_data",  64'(dob2),       64'(56'h0));
      check("last_entry_err",   64'(addr_err2),  64'd0);

      // Reset with a read still in the second stage
      enb2 = 1'b1; addrb2 = 6'd2;
      tick();
      enb2 = 1'b0; reset2 = 1'b1;
      tick();
      check("d48_flush_valid", 64'(dob_valid2), 64'd0);
      check("d48_flush_dob",   64'(dob2),       64'd0);
      check("d48_flush_done",  64'(init_done2), 64'd0);
      reset2 = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
